// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide.
// Optional `MDU_ZERO_SKIP_EN: multiplies with a zero operand take the one-cycle fast path.
module mdu_iterative #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] srcA_i,
  input  logic [DATA_WIDTH-1:0] srcB_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);
  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(W - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  typedef enum logic [2:0] {
    OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011,
    OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM    = 3'b110, OP_REMU  = 3'b111
  } op_e;

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic                 sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [W-1:0]         a_mag_q, a_mag_d, b_mag_q, b_mag_d;
  logic [2*W-1:0]       prod_q, prod_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [W-1:0]         result_q, result_d;

  // One iteration of each algorithm; prod_q holds {hi, lo} for both.
  logic [W:0]     mul_sum, div_shift, div_diff;
  logic           div_ge;
  logic [2*W-1:0] mul_next, div_next, step_next, prod_fix;
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, a_mag_q} : '0);
    mul_next  = {mul_sum, prod_q[W-1:1]};
    div_shift = prod_q[2*W-1:W-1];
    div_ge    = div_shift >= {1'b0, b_mag_q};
    div_diff  = div_shift - {1'b0, b_mag_q};
    div_next  = {(div_ge ? div_diff[W-1:0] : div_shift[W-1:0]), prod_q[W-2:0], div_ge};
    step_next = op_q[2] ? div_next : mul_next;
    prod_fix  = (sign_a_q ^ sign_b_q) ? -step_next : step_next;
  end

  // Operand decode for the accepting cycle.
  logic         a_signed, b_signed, in_sign_a, in_sign_b, div_zero, div_ovf, mul_zero;
  logic [W-1:0] in_a_mag, in_b_mag;
  always_comb begin
    a_signed  = (op_i != OP_MULHU) && (op_i != OP_DIVU) && (op_i != OP_REMU);
    b_signed  = a_signed && (op_i != OP_MULHSU);
    in_sign_a = a_signed && srcA_i[W-1];
    in_sign_b = b_signed && srcB_i[W-1];
    in_a_mag  = in_sign_a ? -srcA_i : srcA_i;
    in_b_mag  = in_sign_b ? -srcB_i : srcB_i;
    div_zero  = op_i[2] && (srcB_i == '0);
    div_ovf   = op_i[2] && !op_i[0] && (srcA_i == {1'b1, {(W-1){1'b0}}}) && (&srcB_i);
`ifdef MDU_ZERO_SKIP_EN
    mul_zero  = !op_i[2] && ((srcA_i == '0) || (srcB_i == '0));
`else
    mul_zero  = 1'b0;
`endif
  end

  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: if (start_i) begin
        op_d     = op_e'(op_i);
        sign_a_d = in_sign_a;
        sign_b_d = in_sign_b;
        a_mag_d  = in_a_mag;
        b_mag_d  = in_b_mag;
        cnt_d    = '0;
        prod_d   = {{W{1'b0}}, (op_i[2] ? in_a_mag : in_b_mag)};
        if (div_zero) begin
          result_d = op_i[1] ? srcA_i : '1;
          state_d  = DONE;
        end else if (div_ovf) begin
          result_d = op_i[1] ? '0 : srcA_i;
          state_d  = DONE;
        end else if (mul_zero) begin
          result_d = '0;
          state_d  = DONE;
        end else begin
          state_d  = CALC;
        end
      end
      CALC: begin
        prod_d = step_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
          unique case (op_q)
            OP_MUL:                       result_d = prod_fix[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[2*W-1:W];
            OP_DIV, OP_DIVU:              result_d = prod_fix[W-1:0];
            default:                      result_d = sign_a_q ? -step_next[2*W-1:W]
                                                              : step_next[2*W-1:W];
          endcase
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q == CALC);
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;
endmodule
